// File: rtl/data_memory_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : data_memory_responder_pkg                                   |
// | Brief  : shared constants, FSM encoding and width helper             |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
package data_memory_responder_pkg;

  localparam int c_WORD_W = 32;
  localparam int c_ADDR_W = 32;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_WAIT = 2'd1;
  localparam logic [1:0] c_ST_RESP = 2'd2;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_memory_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : data_memory_responder_if                                    |
// | Brief  : data-memory request/response bus with initiator/responder   |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
interface data_memory_responder_if;
  import data_memory_responder_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [c_ADDR_W-1:0] req_addr;
  logic [c_WORD_W-1:0] req_wdata;
  logic                resp_valid;
  logic [c_WORD_W-1:0] resp_rdata;
  logic                resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error
  );

endinterface
`default_nettype wire

// File: rtl/data_memory_responder_mem_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : data_memory_responder_mem_array                             |
// | Brief  : word store, sync write, registered read, sync clear         |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module data_memory_responder_mem_array
  import data_memory_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_wr_en,
  input  logic [IDX_W-1:0]    i_wr_idx,
  input  logic [c_WORD_W-1:0] i_wr_data,
  input  logic                i_rd_en,
  input  logic                i_rd_zero,
  input  logic [IDX_W-1:0]    i_rd_idx,
  output logic [c_WORD_W-1:0] o_rd_data
);

  logic [c_WORD_W-1:0] r_mem [DEPTH_WORDS];
  logic [c_WORD_W-1:0] r_rd_data;

  // The read register holds between reads so the response data stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_data <= '0;
    end else begin
      if (i_wr_en) r_mem[i_wr_idx] <= i_wr_data;
      if (i_rd_en) r_rd_data <= i_rd_zero ? '0 : r_mem[i_rd_idx];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/data_memory_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : data_memory_responder                                       |
// | Brief  : fixed-latency data-memory responder with address checking   |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int                  DEPTH_WORDS = 64,
  parameter int                  LATENCY     = 2,
  parameter logic [c_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  data_memory_responder_if.slave  bus
);

  localparam int                  c_IDX_W  = clog2(DEPTH_WORDS);
  localparam logic [c_ADDR_W-1:0] c_SPAN   = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]          c_LAT_M1 = 4'(LATENCY - 1);

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_nxt;
  logic                w_accept;
  logic                w_to_resp;
  logic                r_ready;
  logic                r_resp_valid;
  logic                r_resp_error;
  logic                r_write;
  logic [c_ADDR_W-1:0] r_addr;
  logic [c_WORD_W-1:0] r_wdata;

  logic                w_d_write;
  logic [c_ADDR_W-1:0] w_d_addr;
  logic [c_WORD_W-1:0] w_d_wdata;
  logic [c_ADDR_W-1:0] w_off;
  logic                w_err;
  logic [c_IDX_W-1:0]  w_idx;
  logic [c_WORD_W-1:0] w_rd_data;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        if (bus.req_valid && r_ready) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = c_LAT_M1;
          w_state_nxt = (LATENCY == 1) ? c_ST_RESP : c_ST_WAIT;
        end
      end
      c_ST_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_nxt = c_ST_RESP;
      end
      c_ST_RESP: w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  assign w_to_resp = (w_state_nxt == c_ST_RESP) && (r_state != c_ST_RESP);

  // With LATENCY=1 the access completes on the accepting edge, so decode
  // straight from the bus while idle; otherwise the latched copy is used.
  assign w_d_write = (r_state == c_ST_IDLE) ? bus.req_write : r_write;
  assign w_d_addr  = (r_state == c_ST_IDLE) ? bus.req_addr  : r_addr;
  assign w_d_wdata = (r_state == c_ST_IDLE) ? bus.req_wdata : r_wdata;

  assign w_off = w_d_addr - BASE_ADDR;
  assign w_err = (w_d_addr[1:0] != 2'b00) || (w_off >= c_SPAN);
  assign w_idx = w_off[c_IDX_W+1:2];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= c_ST_IDLE;
      r_cnt        <= '0;
      r_ready      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_ready      <= (w_state_nxt == c_ST_IDLE);
      r_resp_valid <= w_to_resp;
      if (w_to_resp) r_resp_error <= w_err;
      if (w_accept) begin
        r_write <= bus.req_write;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
      end
    end
  end

  data_memory_responder_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (c_IDX_W)
  ) u_mem (
    .clk       (clk),
    .rst       (reset),
    .i_wr_en   (w_to_resp && w_d_write && !w_err),
    .i_wr_idx  (w_idx),
    .i_wr_data (w_d_wdata),
    .i_rd_en   (w_to_resp),
    .i_rd_zero (w_d_write || w_err),
    .i_rd_idx  (w_idx),
    .o_rd_data (w_rd_data)
  );

  assign bus.req_ready  = r_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = w_rd_data;
  assign bus.resp_error = r_resp_error;

endmodule
`default_nettype wire
